host_cmd_rx: RTL and testbench
==============================

Name: host_cmd_rx

Overview:
- Host-to-FPGA command receiver on the FT245 synchronous-FIFO port; the upstream end of the link the radar pipeline uses to stream FFT frames to the host.
- Arbitrates read access to the shared FT245 bus with the transmit path.
- Parses fixed 4-byte command frames and drives the run/stop and configuration inputs of the radar control FSM.

Parameters:
TIMEOUT_CYCLES, 60000, idle clk cycles allowed between bytes of a partially received frame before the frame is abandoned
AVG_LG_MAX, 6, largest legal log2 averaging count accepted by SET_AVG
AVG_LG_RST, 6, reset value of cfg_avg_lg

Ports:
clk  in  1  FT245 60 MHz clock
rst_n  in  1  synchronous, active-low reset
ft_rxf_n  in  1  FT245 RX-FIFO-not-empty, active low
ft_data  in  8  FT245 data bus, read direction
ft_oe_n  out  1  FT245 output enable, active low, registered
ft_rd_n  out  1  FT245 read strobe, active low, registered
tx_req  in  1  transmit path requests the bus
rx_busy  out  1  high while ft_oe_n is low; TX must not drive the bus
cmd_start  out  1  one-cycle pulse: begin acquisition
cmd_stop  out  1  one-cycle pulse: halt acquisition
running  out  1  acquisition-enabled status
cfg_avg_lg  out  3  log2 FIR averaging count
cfg_out_sel  out  2  stream select: 0 raw, 1 FIR, 2 window, 3 FFT
err_cnt  out  8  saturating count of bad frames

Behaviour:
Reset values:
- ft_oe_n=1, ft_rd_n=1, rx_busy=0, cmd_start=0, cmd_stop=0, running=0.
- cfg_avg_lg=AVG_LG_RST, cfg_out_sel=3, err_cnt=0.
- Both FSMs return to their initial state and the timeout counter clears. Reset mid-frame discards all partial frame data.

Bus FSM:
- B_IDLE: oe_n=1, rd_n=1.
  - Go to B_OE when ft_rxf_n=0 and tx_req=0.
  - If tx_req=1, stay in B_IDLE regardless of ft_rxf_n. TX has priority when both are pending.
- B_OE: oe_n=0, rd_n=1, for exactly one cycle (bus turnaround), then go to B_RD.
- B_RD: oe_n=0, rd_n=0.
  - A byte is accepted on every rising clk edge where ft_rd_n=0 and ft_rxf_n=0. ft_data is sampled at that edge.
  - Return to B_IDLE when ft_rxf_n=1 or tx_req=1. Both strobes deassert on the next edge.
  - A byte sampled on the exit edge is still accepted.

Frame format: 0xA5, CMD, ARG, SUM, where SUM = CMD xor ARG.

Parser FSM (P_HDR, P_CMD, P_ARG, P_SUM), advances one state per accepted byte:
- P_HDR: non-0xA5 bytes are discarded silently, with no error.
- P_CMD, P_ARG, P_SUM:
  - The timeout counter clears on each accepted byte.
  - On reaching TIMEOUT_CYCLES: go to P_HDR and increment err_cnt.
- SUM mismatch: increment err_cnt, go to P_HDR, no command effect.

Command execution: registered outputs update on the clk edge after the SUM byte is accepted (1-cycle latency).
- 0x01 START: if running=0, set running=1 and pulse cmd_start. If already running, no pulse, no error.
- 0x02 STOP: if running=1, clear running and pulse cmd_stop. Otherwise no effect.
- 0x03 SET_AVG: requires running=0 and ARG ≤ AVG_LG_MAX; then cfg_avg_lg=ARG[2:0]. Otherwise err_cnt++ and cfg unchanged.
- 0x04 SET_SEL: requires running=0 and ARG[7:2]=0; then cfg_out_sel=ARG[1:0]. Otherwise err_cnt++.
- Any other CMD: err_cnt++.

Counters and pulses:
- err_cnt saturates at 255. Two error sources never coincide in the same cycle.
- cmd_start and cmd_stop are never high simultaneously and never longer than one cycle.
- Back-to-back frames with no gap between them are fully supported.

Test Plan:
- Reset, then feed A5 01 00 01 with rxf_n held low → oe_n low one cycle before rd_n; running=1 and cmd_start pulses once, 1 cycle after the SUM byte; err_cnt=0.
- Idle (running=0); send A5 03 04 07 then A5 04 01 05 back-to-back → cfg_avg_lg=4, cfg_out_sel=1, err_cnt=0.
- Running=1: send A5 03 02 01 → cfg_avg_lg unchanged, err_cnt=1. Send A5 03 07 04 while idle → err_cnt=2. Send A5 01 00 00 (bad SUM) → err_cnt=3, no cmd_start.
- Send A5 02, then raise rxf_n for TIMEOUT_CYCLES cycles → err_cnt increments by exactly 1. A following A5 02 00 02 then stops cleanly (cmd_stop pulses if running).
- Assert tx_req mid-frame after 2 bytes → oe_n/rd_n deassert within 1 cycle and rx_busy=0. Deassert tx_req → remaining 2 bytes are read and the frame executes correctly. No byte is lost or duplicated.
- Send stream 00 FF A5 01 00 01 → leading junk is ignored, the START executes, err_cnt=0. Drive 300 bad-SUM frames → err_cnt holds at 255.

Source files
------------

// File: rtl/host_cmd_rx.sv
// rtl/host_cmd_rx.sv - FT245 sync-FIFO command receiver: bus read arbitration and 4-byte frame parser
module host_cmd_rx #(
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int AVG_LG_MAX     = 6,
  parameter int AVG_LG_RST     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ft_rxf_n,
  input  logic [7:0] ft_data,
  output logic       ft_oe_n,
  output logic       ft_rd_n,
  input  logic       tx_req,
  output logic       rx_busy,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic       running,
  output logic [2:0] cfg_avg_lg,
  output logic [1:0] cfg_out_sel,
  output logic [7:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {B_IDLE, B_OE, B_RD} bus_state_e;
  typedef enum logic [1:0] {P_HDR, P_CMD, P_ARG, P_SUM} prs_state_e;

  bus_state_e    bus_q, bus_d;
  prs_state_e    prs_q, prs_d;
  logic          oe_n_q, oe_n_d, rd_n_q, rd_n_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cmd_q, cmd_d, arg_q, arg_d;
  logic          exe_vld_q, exe_vld_d, exe_ok_q, exe_ok_d;
  logic          running_q, running_d, start_q, start_d, stop_q, stop_d;
  logic [2:0]    avg_q, avg_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    err_q, err_d;
  logic          byte_acc, tmo_err, cmd_err;

  assign byte_acc = ~rd_n_q & ~ft_rxf_n;

  // Strobes are registered from the next bus state so the pins change cleanly on the edge.
  always_comb begin
    bus_d  = bus_q;
    oe_n_d = 1'b1;
    rd_n_d = 1'b1;
    case (bus_q)
      B_IDLE: begin
        if (!ft_rxf_n && !tx_req) begin
          bus_d  = B_OE;
          oe_n_d = 1'b0;
        end
      end
      B_OE: begin
        bus_d  = B_RD;
        oe_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      B_RD: begin
        if (ft_rxf_n || tx_req) begin
          bus_d = B_IDLE;
        end else begin
          oe_n_d = 1'b0;
          rd_n_d = 1'b0;
        end
      end
      default: bus_d = B_IDLE;
    endcase
  end

  always_comb begin
    prs_d     = prs_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    exe_vld_d = 1'b0;
    exe_ok_d  = 1'b0;
    tmo_err   = 1'b0;
    if (prs_q == P_HDR) begin
      tmo_d = '0;
      if (byte_acc && ft_data == 8'hA5) prs_d = P_CMD;
    end else if (byte_acc) begin
      tmo_d = '0;
      case (prs_q)
        P_CMD: begin
          cmd_d = ft_data;
          prs_d = P_ARG;
        end
        P_ARG: begin
          arg_d = ft_data;
          prs_d = P_SUM;
        end
        default: begin
          exe_vld_d = 1'b1;
          exe_ok_d  = (ft_data == (cmd_q ^ arg_q));
          prs_d     = P_HDR;
        end
      endcase
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      prs_d   = P_HDR;
      tmo_d   = '0;
      tmo_err = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // cmd_q/arg_q stay stable through the execute cycle: the next frame's CMD lands two edges later.
  always_comb begin
    running_d = running_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    avg_d     = avg_q;
    sel_d     = sel_q;
    cmd_err   = 1'b0;
    if (exe_vld_q) begin
      if (!exe_ok_q) begin
        cmd_err = 1'b1;
      end else begin
        case (cmd_q)
          8'h01: if (!running_q) begin
            running_d = 1'b1;
            start_d   = 1'b1;
          end
          8'h02: if (running_q) begin
            running_d = 1'b0;
            stop_d    = 1'b1;
          end
          8'h03: if (!running_q && arg_q <= 8'(AVG_LG_MAX)) avg_d = arg_q[2:0];
                 else cmd_err = 1'b1;
          8'h04: if (!running_q && arg_q[7:2] == 6'd0) sel_d = arg_q[1:0];
                 else cmd_err = 1'b1;
          default: cmd_err = 1'b1;
        endcase
      end
    end
    err_d = ((cmd_err || tmo_err) && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_q     <= B_IDLE;
      prs_q     <= P_HDR;
      oe_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      tmo_q     <= '0;
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      exe_vld_q <= 1'b0;
      exe_ok_q  <= 1'b0;
      running_q <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      avg_q     <= 3'(AVG_LG_RST);
      sel_q     <= 2'd3;
      err_q     <= 8'h00;
    end else begin
      bus_q     <= bus_d;
      prs_q     <= prs_d;
      oe_n_q    <= oe_n_d;
      rd_n_q    <= rd_n_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      exe_vld_q <= exe_vld_d;
      exe_ok_q  <= exe_ok_d;
      running_q <= running_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      avg_q     <= avg_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
    end
  end

  assign ft_oe_n     = oe_n_q;
  assign ft_rd_n     = rd_n_q;
  assign rx_busy     = ~oe_n_q;
  assign cmd_start   = start_q;
  assign cmd_stop    = stop_q;
  assign running     = running_q;
  assign cfg_avg_lg  = avg_q;
  assign cfg_out_sel = sel_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_host_cmd_rx.sv
// tb/tb_host_cmd_rx.sv - directed and randomized bench for host_cmd_rx against a byte-queue reference model
module tb_host_cmd_rx;
  localparam int T    = 400;
  localparam int AMAX = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ft_rxf_n = 1'b1;
  logic [7:0] ft_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       ft_oe_n, ft_rd_n, rx_busy, cmd_start, cmd_stop, running;
  logic [2:0] cfg_avg_lg;
  logic [1:0] cfg_out_sel;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  host_cmd_rx #(.TIMEOUT_CYCLES(T), .AVG_LG_MAX(AMAX), .AVG_LG_RST(6)) dut (
    .clk(clk), .rst_n(rst_n), .ft_rxf_n(ft_rxf_n), .ft_data(ft_data),
    .ft_oe_n(ft_oe_n), .ft_rd_n(ft_rd_n), .tx_req(tx_req), .rx_busy(rx_busy),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .running(running),
    .cfg_avg_lg(cfg_avg_lg), .cfg_out_sel(cfg_out_sel), .err_cnt(err_cnt)
  );

  int n_tests = 0, n_fail = 0;
  logic [7:0] q[$];
  bit pause = 0;
  int acc_total = 0, tick_no = 0, first_oe = -1, first_rd = -1, n_start = 0, n_stop = 0;
  logic busy_at_rd = 1'b0;

  // reference model: frame buffer of bytes since the last header, effects applied one tick later
  logic [7:0] fb[$];
  int idle = 0;
  bit pend = 0;
  logic [7:0] pc, pa, ps;
  bit m_run, m_start, m_stop;
  logic [2:0] m_avg;
  logic [1:0] m_sel;
  int m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    fb.delete(); idle = 0; pend = 0;
    m_run = 0; m_start = 0; m_stop = 0; m_avg = 3'd6; m_sel = 2'd3; m_err = 0;
  endfunction

  function automatic void err_inc();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_exec();
    if (ps != (pc ^ pa)) err_inc();
    else if (pc == 8'h01) begin
      if (!m_run) begin m_run = 1; m_start = 1; end
    end else if (pc == 8'h02) begin
      if (m_run) begin m_run = 0; m_stop = 1; end
    end else if (pc == 8'h03) begin
      if (!m_run && pa <= AMAX) m_avg = pa[2:0]; else err_inc();
    end else if (pc == 8'h04) begin
      if (!m_run && pa < 4) m_sel = pa[1:0]; else err_inc();
    end else err_inc();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (fb.size() == 0 && b != 8'hA5) return;
    fb.push_back(b);
    idle = 0;
    if (fb.size() == 4) begin
      pend = 1; pc = fb[1]; pa = fb[2]; ps = fb[3];
      fb.delete();
    end
  endfunction

  task automatic tick();
    bit acc;
    logic [7:0] b;
    ft_rxf_n = (q.size() == 0) || pause;
    ft_data  = (q.size() != 0) ? q[0] : 8'($urandom);
    acc = rst_n && (ft_rd_n === 1'b0) && (ft_rxf_n === 1'b0);
    b = ft_data;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_start = 0; m_stop = 0;
      if (pend) begin pend = 0; model_exec(); end
      if (acc) begin
        void'(q.pop_front());
        acc_total++;
        model_byte(b);
      end else if (fb.size() != 0) begin
        idle++;
        if (idle == T) begin fb.delete(); idle = 0; err_inc(); end
      end
    end
    @(negedge clk);
    tick_no++;
    if (first_oe < 0 && ft_oe_n === 1'b0) first_oe = tick_no;
    if (first_rd < 0 && ft_rd_n === 1'b0) begin first_rd = tick_no; busy_at_rd = rx_busy; end
    if (cmd_start === 1'b1) n_start++;
    if (cmd_stop === 1'b1) n_stop++;
    chk("running", running, m_run);
    chk("cmd_start", cmd_start, m_start);
    chk("cmd_stop", cmd_stop, m_stop);
    chk("cfg_avg_lg", cfg_avg_lg, m_avg);
    chk("cfg_out_sel", cfg_out_sel, m_sel);
    chk("err_cnt", err_cnt, m_err);
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    q.push_back(a); q.push_back(b); q.push_back(c); q.push_back(d);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((q.size() != 0 || pend) && k < 5000) begin tick(); k++; end
    chk({tag, "_drain"}, 32'(q.size()), 0);
    tick(); tick();
  endtask

  task automatic do_reset();
    q.delete(); pause = 0; tx_req = 0; rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
  endtask

  initial begin
    int a0, k;
    logic [7:0] c, a, s;
    @(negedge clk);
    do_reset();
    chk("rst_oe_n", ft_oe_n, 1); chk("rst_rd_n", ft_rd_n, 1); chk("rst_busy", rx_busy, 0);
    chk("rst_avg", cfg_avg_lg, 6); chk("rst_sel", cfg_out_sel, 3); chk("rst_err", err_cnt, 0);

    first_oe = -1; first_rd = -1; n_start = 0;
    push4(8'hA5, 8'h01, 8'h00, 8'h01);
    drain("start1");
    chk("oe_before_rd", 32'(first_rd - first_oe), 1);
    chk("busy_at_rd", busy_at_rd, 1);
    chk("start_once", 32'(n_start), 1);
    chk("start_run", running, 1); chk("start_err", err_cnt, 0);

    push4(8'hA5, 8'h02, 8'h00, 8'h02);
    push4(8'hA5, 8'h03, 8'h04, 8'h07);
    push4(8'hA5, 8'h04, 8'h01, 8'h05);
    drain("cfg");
    chk("cfg_avg4", cfg_avg_lg, 4); chk("cfg_sel1", cfg_out_sel, 1); chk("cfg_err0", err_cnt, 0);

    push4(8'hA5, 8'h01, 8'h00, 8'h01);
    push4(8'hA5, 8'h03, 8'h02, 8'h01);
    drain("avg_run");
    chk("avg_run_keep", cfg_avg_lg, 4); chk("avg_run_err", err_cnt, 1);
    push4(8'hA5, 8'h02, 8'h00, 8'h02);
    push4(8'hA5, 8'h03, 8'h07, 8'h04);
    drain("avg_big");
    chk("avg_big_err", err_cnt, 2); chk("avg_big_keep", cfg_avg_lg, 4);
    n_start = 0;
    push4(8'hA5, 8'h01, 8'h00, 8'h00);
    drain("badsum");
    chk("badsum_err", err_cnt, 3); chk("badsum_nostart", 32'(n_start), 0); chk("badsum_run", running, 0);

    push4(8'hA5, 8'h01, 8'h00, 8'h01);
    drain("start2");
    q.push_back(8'hA5); q.push_back(8'h02);
    k = 0;
    while (q.size() != 0 && k < 50) begin tick(); k++; end
    repeat (T - 3) tick();
    chk("tmo_early", err_cnt, 3);
    repeat (8) tick();
    chk("tmo_once", err_cnt, 4);
    n_stop = 0;
    push4(8'hA5, 8'h02, 8'h00, 8'h02);
    drain("stop_after_tmo");
    chk("stop_pulse", 32'(n_stop), 1); chk("stop_run", running, 0); chk("stop_err", err_cnt, 4);

    a0 = acc_total;
    push4(8'hA5, 8'h04, 8'h02, 8'h06);
    k = 0;
    while (acc_total < a0 + 1 && k < 50) begin tick(); k++; end
    tx_req = 1;
    tick();
    chk("tx_bytes2", 32'(acc_total - a0), 2);
    chk("tx_oe_n", ft_oe_n, 1); chk("tx_rd_n", ft_rd_n, 1); chk("tx_busy", rx_busy, 0);
    repeat (6) begin tick(); chk("tx_hold_oe", ft_oe_n, 1); end
    chk("tx_hold_bytes", 32'(acc_total - a0), 2);
    tx_req = 0;
    drain("tx_resume");
    chk("tx_bytes4", 32'(acc_total - a0), 4); chk("tx_sel2", cfg_out_sel, 2); chk("tx_err", err_cnt, 4);

    q.push_back(8'hA5); q.push_back(8'h03); q.push_back(8'h01);
    k = 0;
    while (q.size() != 0 && k < 50) begin tick(); k++; end
    do_reset();
    push4(8'hA5, 8'h04, 8'h00, 8'h04);
    drain("rst_mid");
    chk("rst_mid_sel", cfg_out_sel, 0); chk("rst_mid_err", err_cnt, 0);

    do_reset();
    n_start = 0;
    q.push_back(8'h00); q.push_back(8'hFF);
    push4(8'hA5, 8'h01, 8'h00, 8'h01);
    drain("junk");
    chk("junk_run", running, 1); chk("junk_err", err_cnt, 0); chk("junk_start", 32'(n_start), 1);

    for (int f = 0; f < 60; f++) begin
      c = 8'($urandom_range(0, 5));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
      s = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (c ^ a);
      if ($urandom_range(0, 4) == 0) q.push_back(8'($urandom_range(0, 255)) & 8'h7F);
      if ($urandom_range(0, 9) == 0) begin
        q.push_back(8'hA5); q.push_back(c);
        k = 0;
        while (q.size() != 0 && k < 200) begin tick(); k++; end
        repeat (T + 3) tick();
      end else push4(8'hA5, c, a, s);
      k = 0;
      while (q.size() != 0 && k < 500) begin
        pause  = ($urandom_range(0, 3) == 0);
        tx_req = ($urandom_range(0, 7) == 0);
        tick(); k++;
      end
      pause = 0; tx_req = 0;
    end
    drain("random");

    n_start = 0;
    for (int f = 0; f < 300; f++) push4(8'hA5, 8'h01, 8'h00, 8'h00);
    drain("sat");
    chk("sat_err", err_cnt, 255); chk("sat_nostart", 32'(n_start), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
